bcd_to_n_digit_ca_mux: RTL and testbench

Time-multiplexed driver for an N-digit common-anode 7-segment display. It takes N packed BCD digits plus per-digit decimal points and scans them onto one shared active-low segment bus with one-hot active-low anode selects. Each slot starts with a programmable dead-time to prevent ghosting. Optional leading-zero blanking and frame-synchronous input capture are included. It sits between the numeric datapath and the board display pins, and replaces the single-digit static decoder.

---
 rtl/bcd_to_n_digit_ca_mux.sv | 164 ++++++++++++++++
 tb/tb_bcd_to_n_digit_ca_mux.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bcd_to_n_digit_ca_mux.sv
// Scanned driver for an N-digit common-anode 7-segment display: frame-coherent
// BCD snapshot, per-slot dead-time, optional leading-zero blanking, registered pins.
module bcd_to_n_digit_ca_mux #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   BCD_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [6:0]            Segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     SEL,
  output logic                  frame_tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0]     CNT_MAX   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]     BLANK_LIM = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0]     IDX_MAX   = IW'(DIGITS - 1);
  localparam logic [IW-1:0]     IDX_ONE   = IW'(1);
  localparam logic [DIGITS-1:0] SEL_ONE   = DIGITS'(1);
  localparam logic [6:0]        SEG_BLANK = 7'b111_1111;

  // Active-low gfedcba patterns; codes 10..15 show nothing.
  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = 7'b100_0000;
      4'd1:    pat = 7'b111_1001;
      4'd2:    pat = 7'b010_0100;
      4'd3:    pat = 7'b011_0000;
      4'd4:    pat = 7'b001_1001;
      4'd5:    pat = 7'b001_0010;
      4'd6:    pat = 7'b000_0010;
      4'd7:    pat = 7'b111_1000;
      4'd8:    pat = 7'b000_0000;
      4'd9:    pat = 7'b001_0000;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_bcd_q, snap_bcd_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                snap_lz_q, snap_lz_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                tick_q, tick_d;

  logic                frame_start;
  logic                anode_on;
  logic [3:0]          cur_digit;
  logic [DIGITS-1:0]   lz_zero;
  logic                zero_run;
  logic                lz_blank;

  // Digit selection and leading-zero detection from the frame snapshot.
  always_comb begin
    cur_digit = 4'd0;
    zero_run  = 1'b1;
    lz_zero   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      cur_digit = (idx_q == IW'(k)) ? snap_bcd_q[4*k +: 4] : cur_digit;
    end
    // lz_zero[k] means digits DIGITS-1 down to k are all zero.
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run & (snap_bcd_q[4*k +: 4] == 4'd0);
      lz_zero[k] = zero_run;
    end
    lz_blank = snap_lz_q && (idx_q != '0) && lz_zero[idx_q];
  end

  // Scan counters, snapshot capture and next output values.
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    snap_bcd_d  = snap_bcd_q;
    snap_dp_d   = snap_dp_q;
    snap_lz_d   = snap_lz_q;
    seg_d       = SEG_BLANK;
    dp_d        = 1'b1;
    sel_d       = '1;
    frame_start = (cnt_q == '0) && (idx_q == '0);
    anode_on    = enable && (cnt_q >= BLANK_LIM);
    tick_d      = frame_start;

    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end else begin
      cnt_d = cnt_q + CNT_ONE;
      idx_d = idx_q;
    end

    // Capture lands in dead-time, so the first lit cycle already sees new data.
    if (frame_start) begin
      snap_bcd_d = BCD_in;
      snap_dp_d  = dp_in;
      snap_lz_d  = blank_lz;
    end else begin
      snap_bcd_d = snap_bcd_q;
      snap_dp_d  = snap_dp_q;
      snap_lz_d  = snap_lz_q;
    end

    if (anode_on) begin
      sel_d = ~(SEL_ONE << idx_q);
      dp_d  = ~snap_dp_q[idx_q];
      if (lz_blank) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d = seg_decode(cur_digit);
      end
    end else begin
      sel_d = '1;
      dp_d  = 1'b1;
      seg_d = SEG_BLANK;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      snap_bcd_q <= '0;
      snap_dp_q  <= '0;
      snap_lz_q  <= 1'b0;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      sel_q      <= '1;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      snap_bcd_q <= snap_bcd_d;
      snap_dp_q  <= snap_dp_d;
      snap_lz_q  <= snap_lz_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      sel_q      <= sel_d;
      tick_q     <= tick_d;
    end
  end

  assign Segments   = seg_q;
  assign dp         = dp_q;
  assign SEL        = sel_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_to_n_digit_ca_mux.sv
// Directed bench for bcd_to_n_digit_ca_mux with DIGITS=4, PRESCALE=8, BLANK_CYCLES=2;
// outputs are sampled on the falling edge, one slot position per cycle.
module tb_bcd_to_n_digit_ca_mux;

  localparam int DIGITS       = 4;
  localparam int PRESCALE     = 8;
  localparam int BLANK_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] BCD_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        enable;
  logic [6:0]  Segments;
  logic        dp;
  logic [3:0]  SEL;
  logic        frame_tick;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bcd_to_n_digit_ca_mux #(
    .DIGITS       (DIGITS),
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .BCD_in     (BCD_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .enable     (enable),
    .Segments   (Segments),
    .dp         (dp),
    .SEL        (SEL),
    .frame_tick (frame_tick)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // One output cycle at slot position (d, c); en_off marks a cycle forced dark by enable.
  task automatic chk_cyc(input int d, input int c, input logic [6:0] seg_e,
                         input logic dp_on, input logic en_off);
    logic       act;
    logic [3:0] one_hot;
    logic [3:0] sel_e;
    act     = (c >= BLANK_CYCLES) && !en_off;
    one_hot = 4'b0001;
    sel_e   = act ? ~(one_hot << d) : 4'b1111;
    chk($sformatf("sel d%0d c%0d", d, c), {4'b0000, SEL}, {4'b0000, sel_e});
    chk($sformatf("seg d%0d c%0d", d, c), {1'b0, Segments}, {1'b0, (act ? seg_e : 7'h7F)});
    chk($sformatf("dp d%0d c%0d", d, c), {7'b0000000, dp}, {7'b0000000, (act ? ~dp_on : 1'b1)});
    chk($sformatf("tick d%0d c%0d", d, c), {7'b0000000, frame_tick},
        {7'b0000000, ((d == 0) && (c == 0))});
  endtask

  task automatic chk_slot(input int d, input logic [6:0] seg_e, input logic dp_on);
    for (int c = 0; c < PRESCALE; c++) begin
      chk_cyc(d, c, seg_e, dp_on, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic chk_frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                           input logic [6:0] s0, input logic [3:0] dpv);
    chk_slot(0, s0, dpv[0]);
    chk_slot(1, s1, dpv[1]);
    chk_slot(2, s2, dpv[2]);
    chk_slot(3, s3, dpv[3]);
    chk("frame period", {7'b0000000, frame_tick}, 8'h01);
  endtask

  task automatic sync_frame();
    logic found;
    found = 1'b0;
    for (int i = 0; (i < 40) && !found; i++) begin
      if (frame_tick === 1'b1) begin
        found = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("frame sync", {7'b0000000, found}, 8'h01);
  endtask

  // New inputs are applied before the next capture, then the bench aligns to that frame.
  task automatic load(input logic [15:0] bcd, input logic [3:0] dpv, input logic lz);
    BCD_in   = bcd;
    dp_in    = dpv;
    blank_lz = lz;
    @(negedge clk);
    sync_frame();
  endtask

  initial begin
    rst_n    = 1'b0;
    BCD_in   = 16'h1234;
    dp_in    = 4'b0100;
    blank_lz = 1'b0;
    enable   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset sel", {4'b0000, SEL}, 8'h0F);
    chk("reset seg", {1'b0, Segments}, 8'h7F);
    chk("reset dp", {7'b0000000, dp}, 8'h01);
    chk("reset tick", {7'b0000000, frame_tick}, 8'h00);

    rst_n = 1'b1;
    @(negedge clk);
    chk_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'b0100);
    chk_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'b0100);

    load(16'h0070, 4'b0000, 1'b1);
    chk_frame(7'h7F, 7'h7F, 7'h78, 7'h40, 4'b0000);

    load(16'h0000, 4'b1000, 1'b1);
    chk_frame(7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b1000);

    load(16'hFA09, 4'b0000, 1'b0);
    chk_frame(7'h7F, 7'h7F, 7'h40, 7'h10, 4'b0000);

    load(16'h1111, 4'b0000, 1'b0);
    chk_slot(0, 7'h79, 1'b0);
    chk_slot(1, 7'h79, 1'b0);
    BCD_in = 16'h2222;
    chk_slot(2, 7'h79, 1'b0);
    chk_slot(3, 7'h79, 1'b0);
    chk_frame(7'h24, 7'h24, 7'h24, 7'h24, 4'b0000);

    chk_slot(0, 7'h24, 1'b0);
    for (int c = 0; c < PRESCALE; c++) begin
      chk_cyc(1, c, 7'h24, 1'b0, (c >= 3) && (c <= 7));
      if (c == 2) enable = 1'b0;
      if (c == 7) enable = 1'b1;
      @(negedge clk);
    end
    chk_slot(2, 7'h24, 1'b0);
    chk_slot(3, 7'h24, 1'b0);
    chk("tick after enable", {7'b0000000, frame_tick}, 8'h01);

    chk_slot(0, 7'h24, 1'b0);
    chk_slot(1, 7'h24, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk_cyc(2, c, 7'h24, 1'b0, 1'b0);
      if (c < 3) @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset sel", {4'b0000, SEL}, 8'h0F);
    chk("midreset seg", {1'b0, Segments}, 8'h7F);
    chk("midreset dp", {7'b0000000, dp}, 8'h01);
    chk("midreset tick", {7'b0000000, frame_tick}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk_frame(7'h24, 7'h24, 7'h24, 7'h24, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
